// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises and debounces Start/Stop/Lap buttons and runs the
// run/stop/lap/clear state machine that drives the dek1z counter chain and display hold.
module stopwatch_ctrl #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned DEB_W   = 3
) (
  input  logic       Clk,
  input  logic       RES,
  input  logic       Tick,
  input  logic       StartN,
  input  logic       StopN,
  input  logic       LapN,
  output logic       EN,
  output logic       CLR,
  output logic       HOLD,
  output logic       RUN,
  output logic [1:0] STATE
);

  localparam int unsigned NB       = 3;
  localparam int unsigned BI_START = 0;
  localparam int unsigned BI_STOP  = 1;
  localparam int unsigned BI_LAP   = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_LAP     = 2'b10,
    S_STOPPED = 2'b11
  } state_t;

  logic [NB-1:0]    raw_n;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_d;
  logic [NB-1:0]    press;
  logic [DEB_W-1:0] cnt [NB];

  state_t state;
  state_t state_nxt;

  assign raw_n = {LapN, StopN, StartN};

  // Synchronise, debounce on Tick, and emit a one-Clk pulse after each accepted press.
  always_ff @(posedge Clk or negedge RES) begin
    if (!RES) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      press    <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw_n;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      if (Tick) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (sync2[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == DEB_W'(DEB_CNT - 1)) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Next state; Stop outranks Start, Start outranks Lap, losers are dropped.
  always_comb begin
    state_nxt = state;
    if (press[BI_STOP]) begin
      if (state == S_RUN || state == S_LAP) state_nxt = S_STOPPED;
    end else if (press[BI_START]) begin
      if (state == S_IDLE || state == S_STOPPED) state_nxt = S_RUN;
    end else if (press[BI_LAP]) begin
      case (state)
        S_RUN:     state_nxt = S_LAP;
        S_LAP:     state_nxt = S_RUN;
        S_STOPPED: state_nxt = S_IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  // State and outputs share one register stage so outputs never glitch.
  always_ff @(posedge Clk or negedge RES) begin
    if (!RES) begin
      state <= S_IDLE;
      EN    <= 1'b0;
      CLR   <= 1'b0;
      HOLD  <= 1'b0;
      RUN   <= 1'b0;
    end else begin
      state <= state_nxt;
      EN    <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      RUN   <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      HOLD  <= (state_nxt == S_LAP);
      CLR   <= (state == S_STOPPED) && (state_nxt == S_IDLE);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: debounce latency, bounce rejection, FSM transitions,
// press priority, clear pulse and asynchronous reset behaviour.
module tb_stopwatch_ctrl;

  logic       Clk = 1'b0;
  logic       RES;
  logic       Tick;
  logic       StartN;
  logic       StopN;
  logic       LapN;
  logic       EN;
  logic       CLR;
  logic       HOLD;
  logic       RUN;
  logic [1:0] STATE;

  int checks  = 0;
  int errors  = 0;
  int clr_cnt = 0;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_STOP  = 3'b010;
  localparam logic [2:0] B_LAP   = 3'b100;

  stopwatch_ctrl #(.DEB_CNT(4), .DEB_W(3)) dut (
    .Clk    (Clk),
    .RES    (RES),
    .Tick   (Tick),
    .StartN (StartN),
    .StopN  (StopN),
    .LapN   (LapN),
    .EN     (EN),
    .CLR    (CLR),
    .HOLD   (HOLD),
    .RUN    (RUN),
    .STATE  (STATE)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (CLR === 1'b1) clr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tick1();
    Tick = 1'b1;
    @(negedge Clk);
    Tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick1();
      clks(1);
    end
  endtask

  task automatic set_btn(input logic [2:0] mask);
    {LapN, StopN, StartN} = ~mask;
  endtask

  // Press the masked buttons for n Ticks, release, and let the release settle.
  task automatic press(input logic [2:0] mask, input int n);
    set_btn(mask);
    clks(2);
    ticks(n);
    set_btn(3'b000);
    clks(2);
    ticks(6);
    clks(2);
  endtask

  task automatic check_out(input string tag, input logic en, input logic hold,
                           input logic run, input logic [1:0] st);
    check({tag, "_en"},    8'(EN),    8'(en));
    check({tag, "_hold"},  8'(HOLD),  8'(hold));
    check({tag, "_run"},   8'(RUN),   8'(run));
    check({tag, "_state"}, 8'(STATE), 8'(st));
  endtask

  initial begin
    RES = 1'b0;
    Tick = 1'b0;
    set_btn(3'b000);
    clks(3);
    check_out("reset", 1'b0, 1'b0, 1'b0, 2'b00);
    check("reset_clr", 8'(CLR), 8'd0);
    RES = 1'b1;
    clks(2);

    // 1: Start press, exact EN latency of 2 Clk + 4 Ticks + 2 Clk
    set_btn(B_START);
    clks(2);
    ticks(3);
    tick1();
    check("t1_en_edge0", 8'(EN), 8'd0);
    clks(1);
    check("t1_en_edge1", 8'(EN), 8'd0);
    check("t1_state_edge1", 8'(STATE), 8'd0);
    clks(1);
    check_out("t1_run", 1'b1, 1'b0, 1'b1, 2'b01);
    ticks(2);
    set_btn(3'b000);
    clks(2);
    ticks(6);
    clks(2);
    check_out("t1_after_release", 1'b1, 1'b0, 1'b1, 2'b01);

    // 2: Stop bounces for 3 Ticks, never stable long enough
    set_btn(B_STOP);  clks(2); tick1();
    set_btn(3'b000);  clks(2); tick1();
    set_btn(B_STOP);  clks(2); tick1();
    set_btn(3'b000);  clks(2); ticks(6); clks(2);
    check_out("t2_bounce", 1'b1, 1'b0, 1'b1, 2'b01);

    // 3: Lap held long gives one pulse, Lap again releases, Lap then Stop
    press(B_LAP, 12);
    check_out("t3_lap", 1'b1, 1'b1, 1'b1, 2'b10);
    press(B_LAP, 6);
    check_out("t3_unlap", 1'b1, 1'b0, 1'b1, 2'b01);
    press(B_LAP, 6);
    check("t3_lap2_state", 8'(STATE), 8'd2);
    press(B_STOP, 6);
    check_out("t3_stopped", 1'b0, 1'b0, 1'b0, 2'b11);

    // 4: Lap in STOPPED clears for exactly one Clk
    set_btn(B_LAP);
    clks(2);
    ticks(3);
    tick1();
    clks(1);
    check("t4_clr_before", 8'(CLR), 8'd0);
    check("t4_state_before", 8'(STATE), 8'd3);
    clks(1);
    check("t4_clr_pulse", 8'(CLR), 8'd1);
    check_out("t4_idle", 1'b0, 1'b0, 1'b0, 2'b00);
    clks(1);
    check("t4_clr_after", 8'(CLR), 8'd0);
    ticks(2);
    set_btn(3'b000);
    clks(2);
    ticks(6);
    clks(2);
    check("t4_clr_total", 8'(clr_cnt), 8'd1);

    // 4b: resume from STOPPED keeps count, no clear
    press(B_START, 6);
    press(B_STOP, 6);
    check("t4b_stopped", 8'(STATE), 8'd3);
    press(B_START, 6);
    check_out("t4b_resume", 1'b1, 1'b0, 1'b1, 2'b01);
    check("t4b_no_clr", 8'(clr_cnt), 8'd1);

    // Priority: Stop beats Lap in RUN, Start beats Lap in STOPPED
    press(B_STOP | B_LAP, 6);
    check_out("pri_stop_lap", 1'b0, 1'b0, 1'b0, 2'b11);
    press(B_START | B_LAP, 6);
    check_out("pri_start_lap", 1'b1, 1'b0, 1'b1, 2'b01);
    check("pri_start_lap_clr", 8'(clr_cnt), 8'd1);
    press(B_STOP, 6);
    press(B_LAP, 6);
    check("pri_to_idle", 8'(STATE), 8'd0);
    check("pri_clr_total", 8'(clr_cnt), 8'd2);

    // 5: Start and Stop together in IDLE, Stop wins and is ignored
    press(B_START | B_STOP, 6);
    check_out("t5_idle", 1'b0, 1'b0, 1'b0, 2'b00);

    // 6: reset while in LAP with Lap held
    press(B_START, 6);
    press(B_LAP, 6);
    check_out("t6_lap", 1'b1, 1'b1, 1'b1, 2'b10);
    set_btn(B_LAP);
    clks(2);
    ticks(2);
    #2 RES = 1'b0;
    #1 check_out("t6_async", 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge Clk);
    clks(1);
    RES = 1'b1;
    clks(2);
    ticks(8);
    clks(2);
    check_out("t6_lap_held_idle", 1'b0, 1'b0, 1'b0, 2'b00);
    set_btn(3'b000);
    clks(2);
    ticks(6);
    clks(2);

    // 6b: Start held across reset release needs a full debounce afterwards
    set_btn(B_START);
    clks(1);
    RES = 1'b0;
    clks(2);
    ticks(2);
    RES = 1'b1;
    clks(2);
    ticks(3);
    tick1();
    clks(1);
    check("t6b_en_edge1", 8'(EN), 8'd0);
    clks(1);
    check_out("t6b_run", 1'b1, 1'b0, 1'b1, 2'b01);
    set_btn(3'b000);
    clks(2);
    ticks(6);
    clks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
